traffic_scheduler: RTL and testbench
====================================

Name: traffic_scheduler

Overview:
- Multi-stream command generator and round-robin arbiter that feeds the command FIFO in front of the Ethernet frame builder.
- Holds N_STREAMS configured frame profiles (size, MACs, ethertype, fill byte, packet count, inter-packet gap).
- Arbitrates among eligible streams and writes one command word per grant into the FIFO write side.
- Sequences whole test runs with start/stop and reports completion.

Parameters:
N_STREAMS, 4, number of stream profiles (2..16)
CNT_WIDTH, 32, width of per-stream packet count and total-sent counter
GAP_WIDTH, 16, width of per-stream inter-packet gap (clock cycles)

Ports:
clk  in  1  clock
rst  in  1  reset
cfg_wr_en  in  1  config write strobe
cfg_stream  in  $clog2(N_STREAMS)  target stream index
cfg_addr  in  3  field: 0 size, 1 d_mac, 2 s_mac, 3 ethertype, 4 payload, 5 pkt_count, 6 gap, 7 enable (bit0)
cfg_wdata  in  48  write data, LSB-aligned
cfg_err  out  1  one-cycle pulse: write rejected while busy
start  in  1  begin run (level sampled, acted on in IDLE only)
stop  in  1  abort run
fifo_full  in  1  command FIFO full
fifo_wr_enable  out  1  command FIFO write strobe
size  out  11  frame size in bytes
d_mac  out  48  destination MAC
s_mac  out  48  source MAC
ethertype  out  16  ethertype
payload  out  8  fill byte
busy  out  1  high in RUN
done  out  1  one-cycle pulse at run end
sent_total  out  CNT_WIDTH  commands written this run

Behaviour:
- Reset: synchronous, active-high. Clears all profile registers, enable bits, counters and rr_ptr. Forces IDLE. All outputs reset to 0.
- Config writes: accepted only in IDLE. The field is truncated to its width.
  - size is clamped on write to 60..1514; values outside that range store the nearest bound.
  - pkt_count=0 means infinite.
  - A write in RUN is ignored and cfg_err pulses on the next cycle.
- FSM states: IDLE, RUN.
  - IDLE -> RUN on start. On that edge: remaining[s] <= pkt_count[s], gap_cnt[s] <= 0, sent_total <= 0, rr_ptr <= 0.
  - If no stream is enabled at start, stay in IDLE and pulse done the next cycle.
- Eligibility (RUN): eligible[s] = enable[s] & (pkt_count[s]==0 | remaining[s]!=0) & gap_cnt[s]==0.
- Grant: granted when !fifo_full & !fifo_wr_enable & any eligible.
  - Winner is the first eligible index at or after rr_ptr, wrapping modulo N_STREAMS.
  - Because the previous strobe blocks a grant, at most one write occurs per two cycles, so fifo_full is always current.
- On grant, next edge:
  - Command outputs load the winner's profile and fifo_wr_enable=1 for exactly one cycle.
  - rr_ptr <= winner+1 (wraps).
  - remaining[winner] decrements if finite.
  - gap_cnt[winner] <= gap[winner].
  - sent_total increments (saturating).
- Gap counters: every nonzero gap_cnt decrements by 1 each RUN cycle, except the one just loaded. gap=0 makes a stream eligible again immediately.
- Command outputs hold their last value while fifo_wr_enable=0.
- Completion: when every enabled stream is finite with remaining==0 and no write is pending, RUN -> IDLE and done pulses once.
  - Streams with infinite count run until stop.
- Stop: RUN -> IDLE on the next edge. A write already registered in the same cycle still completes (its strobe is not suppressed). No further grants. done pulses once.
- Simultaneous events:
  - start together with stop in IDLE: start is ignored.
  - stop together with the final grant: the grant completes and done pulses once.
- Reset mid-run: aborts immediately; fifo_wr_enable is 0 on the next cycle and done does not pulse.
- busy = (state==RUN).

Decomposition:
- Shared package holds:
  - cfg_addr field codes (CFG_SIZE..CFG_ENABLE).
  - MIN_FRAME=60 and MAX_FRAME=1514.
  - Command field widths (11/48/48/16/8).
  - FSM state encoding.
- One natural sub-module: rr_arbiter, a parameterised N-input round-robin priority picker taking eligible vector + rr_ptr and returning winner index + any_valid. It is purely combinational; the pointer register stays in the parent.

Test Plan:
- Stream0 size=64, pkt_count=3, gap=0, only stream enabled; start -> three writes on cycles 2,4,6 after start, each size=64; sent_total=3; done pulses once; busy drops.
- Streams 0,1,2 enabled, count=2, gap=0 -> grant order 0,1,2,0,1,2; done after the sixth write.
- Stream0 gap=10, count=2 -> the second write lands 11 cycles after the first, not earlier.
- fifo_full held high 20 cycles mid-run -> no fifo_wr_enable during that window; resumes on the cycle after fifo_full falls with no lost or duplicated command.
- Config size=20 then size=2000 -> read back via first write: size=60 and 1514 respectively. Config write during RUN -> cfg_err pulse and profile unchanged.
- Stream0 count=0 (infinite) running; assert stop -> at most one further write, busy low next cycle, done pulse. Second case: rst mid-run -> outputs 0, no done.

Source files
------------

// File: rtl/traffic_scheduler_pkg.sv
// traffic_scheduler_pkg
// Shared definitions for the traffic scheduler: config field codes, frame
// size bounds, command field widths, FSM encoding and the size clamp helper.
package traffic_scheduler_pkg;

  localparam logic [2:0] CFG_SIZE      = 3'd0;
  localparam logic [2:0] CFG_DMAC      = 3'd1;
  localparam logic [2:0] CFG_SMAC      = 3'd2;
  localparam logic [2:0] CFG_ETHERTYPE = 3'd3;
  localparam logic [2:0] CFG_PAYLOAD   = 3'd4;
  localparam logic [2:0] CFG_PKT_COUNT = 3'd5;
  localparam logic [2:0] CFG_GAP       = 3'd6;
  localparam logic [2:0] CFG_ENABLE    = 3'd7;

  localparam int MIN_FRAME = 60;
  localparam int MAX_FRAME = 1514;

  localparam int SIZE_W    = 11;
  localparam int MAC_W     = 48;
  localparam int ETYPE_W   = 16;
  localparam int PAYLOAD_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Out-of-range sizes store the nearest legal bound; the compare is done on
  // the full write word so large values cannot alias into range.
  function automatic logic [SIZE_W-1:0] clamp_size(input logic [47:0] v);
    if (v < 48'(MIN_FRAME))
      clamp_size = SIZE_W'(MIN_FRAME);
    else if (v > 48'(MAX_FRAME))
      clamp_size = SIZE_W'(MAX_FRAME);
    else
      clamp_size = v[SIZE_W-1:0];
  endfunction

endpackage

// File: rtl/traffic_scheduler_rr_arbiter.sv
// traffic_scheduler_rr_arbiter
// Combinational round-robin picker: returns the first eligible index at or
// after rr_ptr, wrapping modulo N.
//   eligible  : per-input request vector
//   rr_ptr    : index with highest priority this cycle
//   winner    : selected index (0 when nothing is eligible)
//   any_valid : at least one input eligible
module traffic_scheduler_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] rr_ptr,
  output logic [W-1:0] winner,
  output logic         any_valid
);

  always_comb begin
    int idx;
    idx       = 0;
    winner    = '0;
    any_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(rr_ptr) + i) % N;
      if (!any_valid && eligible[idx]) begin
        winner    = W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_scheduler.sv
// traffic_scheduler
// Multi-stream frame command generator. Holds per-stream profiles, arbitrates
// eligible streams round-robin and writes one command per grant to the FIFO.
//   clk, rst              : clock, synchronous active-high reset
//   cfg_*                 : profile write port (IDLE only), cfg_err on reject
//   start, stop           : run control
//   fifo_full             : FIFO back-pressure
//   fifo_wr_enable        : one-cycle command strobe
//   size..payload         : command fields, held between strobes
//   busy, done            : run status, done is a one-cycle pulse
//   sent_total            : commands written in the current/last run
module traffic_scheduler
  import traffic_scheduler_pkg::*;
#(
  parameter int N_STREAMS = 4,
  parameter int CNT_WIDTH = 32,
  parameter int GAP_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_wr_en,
  input  logic [$clog2(N_STREAMS)-1:0] cfg_stream,
  input  logic [2:0]                   cfg_addr,
  input  logic [47:0]                  cfg_wdata,
  output logic                         cfg_err,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         fifo_full,
  output logic                         fifo_wr_enable,
  output logic [SIZE_W-1:0]            size,
  output logic [MAC_W-1:0]             d_mac,
  output logic [MAC_W-1:0]             s_mac,
  output logic [ETYPE_W-1:0]           ethertype,
  output logic [PAYLOAD_W-1:0]         payload,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_WIDTH-1:0]         sent_total
);

  localparam int SW = $clog2(N_STREAMS);

  state_t state, state_nxt;

  logic [SIZE_W-1:0]    prof_size    [N_STREAMS];
  logic [MAC_W-1:0]     prof_dmac    [N_STREAMS];
  logic [MAC_W-1:0]     prof_smac    [N_STREAMS];
  logic [ETYPE_W-1:0]   prof_etype   [N_STREAMS];
  logic [PAYLOAD_W-1:0] prof_payload [N_STREAMS];
  logic [CNT_WIDTH-1:0] prof_count   [N_STREAMS];
  logic [GAP_WIDTH-1:0] prof_gap     [N_STREAMS];
  logic [CNT_WIDTH-1:0] remaining    [N_STREAMS];
  logic [GAP_WIDTH-1:0] gap_cnt      [N_STREAMS];
  logic [N_STREAMS-1:0] enable;

  logic [N_STREAMS-1:0] live, eligible;
  logic [SW-1:0]        rr_ptr, winner;
  logic                 any_valid, grant, finish_run, run_start, empty_start;

  // live: enabled and still has packets to send (infinite counts never run out)
  always_comb begin
    live     = '0;
    eligible = '0;
    for (int s = 0; s < N_STREAMS; s++) begin
      live[s]     = enable[s] & ((prof_count[s] == '0) | (remaining[s] != '0));
      eligible[s] = (state == ST_RUN) & live[s] & (gap_cnt[s] == '0);
    end
  end

  traffic_scheduler_rr_arbiter #(.N(N_STREAMS), .W(SW)) u_arb (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // The previous strobe blocks a grant so fifo_full always reflects the last write.
  assign grant       = (state == ST_RUN) & ~fifo_full & ~fifo_wr_enable & any_valid;
  assign finish_run  = (state == ST_RUN) & (stop | ((live == '0) & ~fifo_wr_enable));
  assign run_start   = (state == ST_IDLE) & start & ~stop & (enable != '0);
  assign empty_start = (state == ST_IDLE) & start & ~stop & (enable == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (run_start)  state_nxt = ST_RUN;
      ST_RUN:  if (finish_run) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < N_STREAMS; s++) begin
        prof_size[s]    <= '0;
        prof_dmac[s]    <= '0;
        prof_smac[s]    <= '0;
        prof_etype[s]   <= '0;
        prof_payload[s] <= '0;
        prof_count[s]   <= '0;
        prof_gap[s]     <= '0;
        remaining[s]    <= '0;
        gap_cnt[s]      <= '0;
      end
      enable         <= '0;
      rr_ptr         <= '0;
      cfg_err        <= 1'b0;
      done           <= 1'b0;
      fifo_wr_enable <= 1'b0;
      size           <= '0;
      d_mac          <= '0;
      s_mac          <= '0;
      ethertype      <= '0;
      payload        <= '0;
      sent_total     <= '0;
    end else begin
      cfg_err        <= 1'b0;
      done           <= 1'b0;
      fifo_wr_enable <= 1'b0;

      if (cfg_wr_en) begin
        if (state == ST_IDLE) begin
          case (cfg_addr)
            CFG_SIZE:      prof_size[cfg_stream]    <= clamp_size(cfg_wdata);
            CFG_DMAC:      prof_dmac[cfg_stream]    <= cfg_wdata[MAC_W-1:0];
            CFG_SMAC:      prof_smac[cfg_stream]    <= cfg_wdata[MAC_W-1:0];
            CFG_ETHERTYPE: prof_etype[cfg_stream]   <= cfg_wdata[ETYPE_W-1:0];
            CFG_PAYLOAD:   prof_payload[cfg_stream] <= cfg_wdata[PAYLOAD_W-1:0];
            CFG_PKT_COUNT: prof_count[cfg_stream]   <= cfg_wdata[CNT_WIDTH-1:0];
            CFG_GAP:       prof_gap[cfg_stream]     <= cfg_wdata[GAP_WIDTH-1:0];
            default:       enable[cfg_stream]       <= cfg_wdata[0];
          endcase
        end else begin
          cfg_err <= 1'b1;
        end
      end

      if (run_start) begin
        for (int s = 0; s < N_STREAMS; s++) begin
          remaining[s] <= prof_count[s];
          gap_cnt[s]   <= '0;
        end
        sent_total <= '0;
        rr_ptr     <= '0;
      end

      if (empty_start) done <= 1'b1;

      if (state == ST_RUN) begin
        for (int s = 0; s < N_STREAMS; s++) begin
          if (grant && (winner == SW'(s))) begin
            gap_cnt[s] <= prof_gap[s];
            if (prof_count[s] != '0) remaining[s] <= remaining[s] - CNT_WIDTH'(1);
          end else if (gap_cnt[s] != '0) begin
            gap_cnt[s] <= gap_cnt[s] - GAP_WIDTH'(1);
          end
        end

        if (grant) begin
          fifo_wr_enable <= 1'b1;
          size           <= prof_size[winner];
          d_mac          <= prof_dmac[winner];
          s_mac          <= prof_smac[winner];
          ethertype      <= prof_etype[winner];
          payload        <= prof_payload[winner];
          rr_ptr         <= (winner == SW'(N_STREAMS - 1)) ? '0 : winner + SW'(1);
          if (sent_total != '1) sent_total <= sent_total + CNT_WIDTH'(1);
        end

        if (finish_run) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_traffic_scheduler.sv
module tb_traffic_scheduler;
  import traffic_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_wr_en = 1'b0;
  logic [1:0]  cfg_stream = '0;
  logic [2:0]  cfg_addr = '0;
  logic [47:0] cfg_wdata = '0;
  logic        cfg_err;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        fifo_full = 1'b0;
  logic        fifo_wr_enable;
  logic [10:0] size;
  logic [47:0] d_mac, s_mac;
  logic [15:0] ethertype;
  logic [7:0]  payload;
  logic        busy, done;
  logic [31:0] sent_total;

  traffic_scheduler #(.N_STREAMS(4), .CNT_WIDTH(32), .GAP_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_stream(cfg_stream),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
    .start(start), .stop(stop), .fifo_full(fifo_full),
    .fifo_wr_enable(fifo_wr_enable), .size(size), .d_mac(d_mac), .s_mac(s_mac),
    .ethertype(ethertype), .payload(payload), .busy(busy), .done(done),
    .sent_total(sent_total)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int          wr_cyc[$];
  logic [10:0] wr_size[$];
  logic [47:0] wr_dmac[$];
  logic [47:0] wr_smac[$];
  logic [15:0] wr_etype[$];
  logic [7:0]  wr_pay[$];
  int          done_q[$];
  int          err_q[$];

  // Observe registered outputs 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (fifo_wr_enable === 1'b1) begin
        wr_cyc.push_back(cyc);
        wr_size.push_back(size);
        wr_dmac.push_back(d_mac);
        wr_smac.push_back(s_mac);
        wr_etype.push_back(ethertype);
        wr_pay.push_back(payload);
      end
      if (done === 1'b1)    done_q.push_back(cyc);
      if (cfg_err === 1'b1) err_q.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_q();
    wr_cyc.delete(); wr_size.delete(); wr_dmac.delete(); wr_smac.delete();
    wr_etype.delete(); wr_pay.delete(); done_q.delete(); err_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    clear_q();
  endtask

  task automatic cfg_write(input int s, input logic [2:0] a, input logic [47:0] d);
    cfg_wr_en  = 1'b1;
    cfg_stream = 2'(s);
    cfg_addr   = a;
    cfg_wdata  = d;
    tick();
    cfg_wr_en  = 1'b0;
  endtask

  task automatic setup(input logic [3:0] mask, input int count, input int gap, input int sz);
    for (int s = 0; s < 4; s++) begin
      if (mask[s]) begin
        cfg_write(s, CFG_SIZE, 48'(sz));
        cfg_write(s, CFG_DMAC, 48'h0200_0000_0000 | 48'(s));
        cfg_write(s, CFG_SMAC, 48'h0A0B_0C0D_0E00 | 48'(s));
        cfg_write(s, CFG_ETHERTYPE, 48'h0800);
        cfg_write(s, CFG_PAYLOAD, 48'hA5);
        cfg_write(s, CFG_PKT_COUNT, 48'(count));
        cfg_write(s, CFG_GAP, 48'(gap));
        cfg_write(s, CFG_ENABLE, 48'h1);
      end
    end
  endtask

  task automatic pulse_start(output int k0);
    k0 = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_q.size() == 0 && n < budget) begin
      tick();
      n++;
    end
  endtask

  typedef struct {
    logic [3:0]  mask;
    int          count;
    int          gap;
    int          size_wr;
    int          exp_writes;
    int          exp_size;
    int          exp_spacing;
    logic [31:0] exp_order;     // nibble i = stream id of write i
    int          exp_done_off;  // done cycle relative to the start cycle
  } vec_t;

  vec_t vecs[7];

  initial begin
    int k0, c, n, first_after;

    vecs[0] = '{4'h1, 3, 0,   64,   3,   64,  2, 32'h00000000,  8};
    vecs[1] = '{4'h7, 2, 0,   64,   6,   64,  2, 32'h00210210, 14};
    vecs[2] = '{4'h1, 2, 10,  100,  2,  100, 11, 32'h00000000, 15};
    vecs[3] = '{4'h1, 1, 0,   20,   1,   60,  2, 32'h00000000,  4};
    vecs[4] = '{4'h1, 1, 0,   2000, 1, 1514,  2, 32'h00000000,  4};
    vecs[5] = '{4'h9, 1, 0,   1514, 2, 1514,  2, 32'h00000030,  6};
    vecs[6] = '{4'h0, 1, 0,   64,   0,    0,  2, 32'h00000000,  1};

    tick();
    do_reset();
    chk("rst_wr_en", fifo_wr_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_size", size, 0);
    chk("rst_d_mac", d_mac, 0);
    chk("rst_sent_total", sent_total, 0);

    for (int v = 0; v < 7; v++) begin
      logic [31:0] ord;
      ord = vecs[v].exp_order;
      do_reset();
      setup(vecs[v].mask, vecs[v].count, vecs[v].gap, vecs[v].size_wr);
      pulse_start(k0);
      wait_done(300);
      repeat (3) tick();
      chk($sformatf("v%0d_nwrites", v), wr_cyc.size(), vecs[v].exp_writes);
      for (int i = 0; i < wr_cyc.size() && i < vecs[v].exp_writes; i++) begin
        chk($sformatf("v%0d_size%0d", v, i), wr_size[i], vecs[v].exp_size);
        chk($sformatf("v%0d_stream%0d", v, i), wr_dmac[i][3:0], ord[i*4 +: 4]);
        chk($sformatf("v%0d_cycle%0d", v, i), wr_cyc[i], k0 + 2 + i * vecs[v].exp_spacing);
      end
      if (wr_cyc.size() > 0) begin
        chk($sformatf("v%0d_s_mac", v), wr_smac[0][47:4], 44'h0A0B_0C0D_0E0);
        chk($sformatf("v%0d_etype", v), wr_etype[0], 16'h0800);
        chk($sformatf("v%0d_payload", v), wr_pay[0], 8'hA5);
      end
      chk($sformatf("v%0d_done_count", v), done_q.size(), 1);
      if (done_q.size() > 0)
        chk($sformatf("v%0d_done_cycle", v), done_q[0], k0 + vecs[v].exp_done_off);
      chk($sformatf("v%0d_sent_total", v), sent_total, vecs[v].exp_writes);
      chk($sformatf("v%0d_busy_end", v), busy, 0);
    end

    // fifo_full held 20 cycles mid-run
    do_reset();
    setup(4'h1, 10, 0, 64);
    pulse_start(k0);
    while (cyc < k0 + 3) tick();
    fifo_full = 1'b1;
    while (cyc < k0 + 23) tick();
    fifo_full = 1'b0;
    wait_done(400);
    repeat (2) tick();
    n = 0;
    first_after = -1;
    foreach (wr_cyc[i]) begin
      if (wr_cyc[i] >= k0 + 4 && wr_cyc[i] <= k0 + 23) n++;
      if (wr_cyc[i] > k0 + 23 && first_after < 0) first_after = wr_cyc[i];
    end
    chk("full_writes_in_window", n, 0);
    chk("full_resume_cycle", first_after, k0 + 24);
    chk("full_total_writes", wr_cyc.size(), 10);
    chk("full_sent_total", sent_total, 10);
    chk("full_done_count", done_q.size(), 1);

    // config write during RUN is rejected, profile unchanged
    do_reset();
    setup(4'h1, 5, 0, 64);
    pulse_start(k0);
    while (cyc < k0 + 3) tick();
    cfg_write(0, CFG_SIZE, 48'd200);
    wait_done(300);
    repeat (2) tick();
    chk("cfgrun_err_count", err_q.size(), 1);
    if (err_q.size() > 0) chk("cfgrun_err_cycle", err_q[0], k0 + 4);
    chk("cfgrun_nwrites", wr_cyc.size(), 5);
    if (wr_cyc.size() > 0) chk("cfgrun_last_size", wr_size[wr_cyc.size() - 1], 64);
    clear_q();
    pulse_start(k0);
    wait_done(300);
    repeat (2) tick();
    if (wr_cyc.size() > 0) chk("cfgrun_rerun_size", wr_size[0], 64);
    chk("cfgrun_rerun_total", sent_total, 5);

    // stop during an infinite run
    do_reset();
    setup(4'h1, 0, 0, 64);
    pulse_start(k0);
    while (cyc < k0 + 7) tick();
    stop = 1'b1;
    c = cyc;
    tick();
    stop = 1'b0;
    chk("stop_busy_next", busy, 0);
    repeat (20) tick();
    n = 0;
    first_after = 0;
    foreach (wr_cyc[i]) begin
      if (wr_cyc[i] > c) n++;
      if (wr_cyc[i] > c + 1) first_after++;
    end
    chk("stop_writes_before", (wr_cyc.size() - n) >= 3, 1);
    chk("stop_at_most_one_more", n <= 1, 1);
    chk("stop_no_late_writes", first_after, 0);
    chk("stop_done_count", done_q.size(), 1);
    if (done_q.size() > 0) chk("stop_done_cycle", done_q[0], c + 1);

    // reset mid-run
    do_reset();
    setup(4'h1, 0, 0, 64);
    pulse_start(k0);
    while (cyc < k0 + 7) tick();
    rst = 1'b1;
    c = cyc;
    tick();
    chk("rstrun_wr_en", fifo_wr_enable, 0);
    chk("rstrun_busy", busy, 0);
    chk("rstrun_size", size, 0);
    chk("rstrun_sent_total", sent_total, 0);
    rst = 1'b0;
    repeat (10) tick();
    n = 0;
    foreach (wr_cyc[i]) if (wr_cyc[i] > c) n++;
    chk("rstrun_no_writes", n, 0);
    chk("rstrun_no_done", done_q.size(), 0);

    // start together with stop in IDLE
    do_reset();
    setup(4'h1, 3, 0, 64);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("startstop_busy", busy, 0);
    repeat (6) tick();
    chk("startstop_writes", wr_cyc.size(), 0);
    chk("startstop_done", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
